// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the three-requester mux arbiter.
package mux_arbiter_pkg;

   // Number of requesters (req[0] is requester 1)
   localparam int unsigned NREQ         = 3;
   // Default for the per-grant hold limit, legal range 1..15
   localparam int unsigned MAX_HOLD_DEF = 4;
   // Hold counter width; holds values up to 15
   localparam int unsigned CNT_W        = 4;
   // Round-robin pointer width; stores the index (0..NREQ-1) of the last owner
   localparam int unsigned PTR_W        = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   // Index of the set bit in a one-hot requester vector (0 when none set)
   function automatic logic [PTR_W-1:0] oh2idx(input logic [NREQ-1:0] oh);
      logic [PTR_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (oh[i]) begin
            idx = PTR_W'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// Combinational winner picker: starting at the requester after i_ptr and wrapping,
// returns the first requesting bit as a one-hot vector (zero if nothing requests).
// With i_ptr fixed at NREQ-1 this degenerates to fixed priority 1 > 2 > 3.
module rr_pick
   import mux_arbiter_pkg::*;
(
   input  logic [NREQ-1:0]  i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [NREQ-1:0]  o_win
);

   logic [PTR_W-1:0] w_idx;
   logic             w_found;

   // Walk the requesters in round-robin order from the pointer, keep the first hit
   always_comb begin
      o_win   = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         w_idx = PTR_W'((32'(i_ptr) + k) % NREQ);
         if (!w_found && i_req[w_idx]) begin
            o_win[w_idx] = 1'b1;
            w_found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_arbiter.sv
// Three-requester arbiter with a registered data mux.
// A grant is held while its owner keeps requesting, for at most MAX_HOLD cycles;
// on release the next winner is granted on the following edge without an idle gap,
// the current owner being excluded whenever anyone else is requesting.
// Data of the granted requester appears on mux_op one cycle after its grant.
//
// Build option: define MUX_ARBITER_RR_EN for round-robin selection (search starts
// after the last owner). Without it selection is fixed priority 1 > 2 > 3 and the
// pointer register is not built.
module mux_arbiter
   import mux_arbiter_pkg::*;
#(
   parameter int unsigned DW       = 4,
   // Legal range 1..15 (the hold counter is CNT_W bits wide)
   parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   input  logic [DW-1:0]   ip1,
   input  logic [DW-1:0]   ip2,
   input  logic [DW-1:0]   ip3,
   output logic [NREQ-1:0] gnt,
   output logic [DW-1:0]   mux_op,
   output logic            op_valid
);

   // Counter value on the last permitted grant cycle
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_e           r_state;
   logic [NREQ-1:0]  r_gnt;
   logic [CNT_W-1:0] r_cnt;
   logic [DW-1:0]    r_op;
   logic             r_valid;

   logic [NREQ-1:0]  w_cand;
   logic [NREQ-1:0]  w_win;
   logic             w_release;
   logic [PTR_W-1:0] w_ptr;

`ifdef MUX_ARBITER_RR_EN
   logic [PTR_W-1:0] r_ptr;
   assign w_ptr = r_ptr;
`else
   // Pointer pinned to the last requester, so the search always starts at requester 1
   assign w_ptr = PTR_W'(NREQ - 1);
`endif

   // Candidates exclude the current owner; in IDLE r_gnt is zero so all requests compete
   assign w_cand    = req & ~r_gnt;
   // Owner stopped requesting, or it has used its full hold allowance
   assign w_release = ((req & r_gnt) == '0) || (r_cnt == HOLD_LAST);

   rr_pick u_pick (
      .i_req (w_cand),
      .i_ptr (w_ptr),
      .o_win (w_win)
   );

   // Arbitration FSM: state, registered grant, hold counter and round-robin pointer
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_gnt   <= '0;
         r_cnt   <= '0;
`ifdef MUX_ARBITER_RR_EN
         r_ptr   <= PTR_W'(NREQ - 1);
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (req != '0) begin
                  r_state <= GRANT;
                  r_gnt   <= w_win;
                  r_cnt   <= '0;
`ifdef MUX_ARBITER_RR_EN
                  r_ptr   <= oh2idx(w_win);
`endif
               end
            end
            GRANT: begin
               if (w_release) begin
                  r_cnt <= '0;
                  if (w_cand != '0) begin
                     // Hand over directly to the next winner, no idle cycle
                     r_gnt <= w_win;
`ifdef MUX_ARBITER_RR_EN
                     r_ptr <= oh2idx(w_win);
`endif
                  end else begin
                     // Only the owner (or nobody) wants the bus: drop for one cycle
                     r_state <= IDLE;
                     r_gnt   <= '0;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_gnt   <= '0;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // Output data register: capture the owner's input on every cycle it holds the grant
   always_ff @(posedge clock) begin
      if (reset) begin
         r_op    <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= (r_gnt != '0);
         unique case (r_gnt)
            3'b001:  r_op <= ip1;
            3'b010:  r_op <= ip2;
            3'b100:  r_op <= ip3;
            default: r_op <= r_op;
         endcase
      end
   end

   assign gnt      = r_gnt;
   assign mux_op   = r_op;
   assign op_valid = r_valid;

   // Grant is never more than one-hot
   a_gnt_onehot0: assert property (@(posedge clock) $onehot0(gnt));

   // A grant is only ever given to (or kept by) a requester that was requesting
   a_gnt_had_req: assert property (@(posedge clock)
      !reset |=> ((gnt & ~$past(req)) == '0));

   // Each grant cycle is followed by the owner's data with op_valid set
   a_data_ip1: assert property (@(posedge clock)
      (!reset && gnt[0]) |=> (op_valid && mux_op == $past(ip1)));
   a_data_ip2: assert property (@(posedge clock)
      (!reset && gnt[1]) |=> (op_valid && mux_op == $past(ip2)));
   a_data_ip3: assert property (@(posedge clock)
      (!reset && gnt[2]) |=> (op_valid && mux_op == $past(ip3)));

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter (MAX_HOLD = 4, DW = 4).
// Each vector holds the inputs for one clock edge and the outputs expected right
// after that edge; expectations go into a scoreboard queue when driven and are
// popped and compared once the edge has happened.
module tb_mux_arbiter;

   localparam int unsigned DW = 4;

   logic          clock;
   logic          reset;
   logic [2:0]    req;
   logic [DW-1:0] ip1;
   logic [DW-1:0] ip2;
   logic [DW-1:0] ip3;
   logic [2:0]    gnt;
   logic [DW-1:0] mux_op;
   logic          op_valid;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       rst;
      logic [2:0] req;
      logic [3:0] ip1;
      logic [3:0] ip2;
      logic [3:0] ip3;
      logic [2:0] gnt;
      logic       vld;
      logic [3:0] op;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   mux_arbiter #(
      .DW       (DW),
      .MAX_HOLD (4)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .req      (req),
      .ip1      (ip1),
      .ip2      (ip2),
      .ip3      (ip3),
      .gnt      (gnt),
      .mux_op   (mux_op),
      .op_valid (op_valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ip2 and ip3 are fixed at 5 and C throughout; ip1 varies per vector
   function automatic vec_t mk(input logic rst, input logic [2:0] rq, input logic [3:0] a,
                               input logic [2:0] g, input logic v, input logic [3:0] o);
      vec_t t;
      t.rst = rst;
      t.req = rq;
      t.ip1 = a;
      t.ip2 = 4'h5;
      t.ip3 = 4'hC;
      t.gnt = g;
      t.vld = v;
      t.op  = o;
      return t;
   endfunction

   function automatic logic [2:0] oh(input int n);
      logic [2:0] r;
      r = 3'b001 << (n - 1);
      return r;
   endfunction

   function automatic logic [3:0] ipv(input int n);
      logic [3:0] r;
      case (n)
         1:       r = 4'hA;
         2:       r = 4'h5;
         default: r = 4'hC;
      endcase
      return r;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one vector, push its expectation, wait for the edge, pop and compare
   task automatic apply(input vec_t v, input string tag);
      vec_t e;
      reset = v.rst;
      req   = v.req;
      ip1   = v.ip1;
      ip2   = v.ip2;
      ip3   = v.ip3;
      sb.push_back(v);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      check({tag, ".gnt"},      8'(gnt),      8'(e.gnt));
      check({tag, ".op_valid"}, 8'(op_valid), 8'(e.vld));
      check({tag, ".mux_op"},   8'(mux_op),   8'(e.op));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      int own[16];

      reset = 1'b1;
      req   = '0;
      ip1   = '0;
      ip2   = '0;
      ip3   = '0;

      // Single requester: grant at +1, data at +2, released after 4 cycles, regrant after a gap
      vecs.push_back(mk(1, 3'b000, 4'hA, 3'b000, 0, 4'h0));
      vecs.push_back(mk(0, 3'b001, 4'hA, 3'b001, 0, 4'h0));
      vecs.push_back(mk(0, 3'b001, 4'hA, 3'b001, 1, 4'hA));
      vecs.push_back(mk(0, 3'b001, 4'hA, 3'b001, 1, 4'hA));
      vecs.push_back(mk(0, 3'b001, 4'hA, 3'b001, 1, 4'hA));
      vecs.push_back(mk(0, 3'b001, 4'hA, 3'b000, 1, 4'hA));
      vecs.push_back(mk(0, 3'b001, 4'h3, 3'b001, 0, 4'hA));
      vecs.push_back(mk(0, 3'b001, 4'h3, 3'b001, 1, 4'h3));
      vecs.push_back(mk(0, 3'b000, 4'h3, 3'b000, 1, 4'h3));
      vecs.push_back(mk(0, 3'b000, 4'h3, 3'b000, 0, 4'h3));

      // All three requesting continuously: 4-cycle grants handed over without gaps
`ifdef MUX_ARBITER_RR_EN
      own = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 1, 1, 1, 1};
`else
      own = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1, 2, 2, 2, 2};
`endif
      vecs.push_back(mk(1, 3'b111, 4'hA, 3'b000, 0, 4'h0));
      for (int e = 0; e < 16; e++) begin
         vecs.push_back(mk(0, 3'b111, 4'hA, oh(own[e]), (e != 0),
                           (e == 0) ? 4'h0 : ipv(own[e-1])));
      end
      vecs.push_back(mk(0, 3'b000, 4'hA, 3'b000, 1, ipv(own[15])));

      // Owner drops after 2 cycles with requester 3 waiting: immediate handover, full 4 cycles
      vecs.push_back(mk(1, 3'b000, 4'hA, 3'b000, 0, 4'h0));
      vecs.push_back(mk(0, 3'b001, 4'hA, 3'b001, 0, 4'h0));
      vecs.push_back(mk(0, 3'b101, 4'hA, 3'b001, 1, 4'hA));
      vecs.push_back(mk(0, 3'b100, 4'hA, 3'b100, 1, 4'hA));
      vecs.push_back(mk(0, 3'b100, 4'hA, 3'b100, 1, 4'hC));
      vecs.push_back(mk(0, 3'b100, 4'hA, 3'b100, 1, 4'hC));
      vecs.push_back(mk(0, 3'b100, 4'hA, 3'b100, 1, 4'hC));
      vecs.push_back(mk(0, 3'b100, 4'hA, 3'b000, 1, 4'hC));
      vecs.push_back(mk(0, 3'b000, 4'hA, 3'b000, 0, 4'hC));

      // Reset mid-grant wins over everything; afterwards requester 1 searches first
      vecs.push_back(mk(1, 3'b000, 4'hA, 3'b000, 0, 4'h0));
      vecs.push_back(mk(0, 3'b010, 4'hA, 3'b010, 0, 4'h0));
      vecs.push_back(mk(0, 3'b010, 4'hA, 3'b010, 1, 4'h5));
      vecs.push_back(mk(1, 3'b010, 4'hA, 3'b000, 0, 4'h0));
      vecs.push_back(mk(0, 3'b011, 4'hA, 3'b001, 0, 4'h0));
      vecs.push_back(mk(0, 3'b011, 4'hA, 3'b001, 1, 4'hA));
      vecs.push_back(mk(0, 3'b000, 4'hA, 3'b000, 1, 4'hA));

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i], $sformatf("vec%0d", i));
      end

      // Non-owner request toggling mid-grant neither shortens the grant nor preempts it
      apply(mk(1, 3'b000, 4'hA, 3'b000, 0, 4'h0), "nonowner_rst");
      apply(mk(0, 3'b001, 4'hA, 3'b001, 0, 4'h0), "nonowner_g1");
      apply(mk(0, 3'b011, 4'hA, 3'b001, 1, 4'hA), "nonowner_g2");
      apply(mk(0, 3'b001, 4'hA, 3'b001, 1, 4'hA), "nonowner_drop");
      apply(mk(0, 3'b011, 4'hA, 3'b001, 1, 4'hA), "nonowner_g4");
      apply(mk(0, 3'b011, 4'hA, 3'b010, 1, 4'hA), "nonowner_handover");
      apply(mk(0, 3'b000, 4'hA, 3'b000, 1, 4'h5), "nonowner_release");
      apply(mk(0, 3'b000, 4'hA, 3'b000, 0, 4'h5), "nonowner_idle");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 4, meaning the data width of each input and of the output.
REQ-002 The block SHALL have parameter MAX_HOLD, default 4, meaning the maximum number of consecutive cycles one grant is held (legal range 1..15).
REQ-003 The block SHALL have port clock, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req, input, 3 bits: request from requesters 1..3 (bit 0 = requester 1).
REQ-006 The block SHALL have ports ip1, ip2 and ip3, each input, DW bits: the data of requesters 1, 2 and 3.
REQ-007 The block SHALL have port gnt, output, 3 bits: one-hot or zero grant, registered.
REQ-008 The block SHALL have port mux_op, output, DW bits: the registered data of the granted requester.
REQ-009 The block SHALL have port op_valid, output, 1 bit: mux_op holds data captured under a grant.

Function
REQ-010 The FSM SHALL have two states, IDLE (gnt=0) and GRANT (exactly one gnt bit high).
REQ-011 In IDLE with req!=0 at an edge, the block SHALL select a winner, set gnt to it and enter GRANT; req seen at cycle N gives gnt at N+1.
REQ-012 On every edge where gnt[i]=1, the block SHALL load mux_op <= ip(i+1) and set op_valid=1; otherwise it SHALL set op_valid=0 and hold mux_op; data latency is gnt+1 cycle.
REQ-013 In GRANT, the hold counter SHALL increment each cycle, and the grant SHALL be released when the owner's req is 0 or the counter equals MAX_HOLD-1.
REQ-014 On release with other requests pending, the block SHALL grant the next winner on the following edge without an IDLE cycle and reset the counter to 0; with nothing pending it SHALL return to IDLE.
REQ-015 The owner SHALL be eligible to win re-arbitration on release only if no other req bit is set.
REQ-016 Winner selection SHALL be round-robin from the pointer: search starts at the requester after the last owner, wrapping 3 to 1.
REQ-017 A req bit dropping for a non-owner SHALL have no effect, and new requests arriving mid-grant SHALL wait for release.
REQ-018 gnt SHALL never have more than one bit set, and SHALL never be set for a requester whose req was 0 at the deciding edge.

Reset
REQ-019 While reset=1 at an edge, gnt SHALL go to 0, mux_op to 0, op_valid to 0, state to IDLE, the counter to 0 and the RR pointer to requester 3 (so requester 1 searches first).
REQ-020 Reset asserted mid-grant SHALL take priority over all other events and drop gnt on that edge.

Configuration
REQ-021 With macro MUX_ARBITER_RR_EN defined, winner selection SHALL be round-robin per REQ-016.
REQ-022 With MUX_ARBITER_RR_EN undefined, selection SHALL be fixed priority 1>2>3, the pointer logic SHALL be omitted, and REQ-015 still applies.

Structure
REQ-023 Package mux_arbiter_pkg SHALL hold the state enum (IDLE, GRANT), the requester count constant NREQ=3 and the MAX_HOLD default.
REQ-024 The winner selection SHALL be one sub-module, rr_pick (req, pointer -> one-hot winner), that is purely combinational.

Verification
REQ-025 Reset, then req=001 with ip1=4'hA held -> gnt=001 at cycle 1, mux_op=A with op_valid=1 at cycle 2, and release after 4 cycles of gnt; gnt reasserts 001 only after it drops (no other req).
REQ-026 req=111 continuous with RR enabled -> gnt sequence 001,010,100,001, each for 4 cycles, with no zero gaps.
REQ-027 req=111 with macro undefined -> gnt=001 for 4 cycles, then 010 (owner excluded), then 001.
REQ-028 Owner req drops after 2 grant cycles with req=100 pending -> gnt=100 on the next edge and counter restarts.
REQ-029 reset=1 during gnt=010 -> on the next edge gnt=0, op_valid=0, mux_op=0; after release with req=011 -> gnt=001.
REQ-030 Assertions SHALL hold throughout: $onehot0(gnt); gnt[i] |=> mux_op==$past(ip) and op_valid.
